// File: rtl/ln_stat_sched.sv
// Two-pass LayerNorm statistics sequencer: streams a vector into the mean unit,
// then streams mean-centred values into the variance unit and reports both.
module ln_stat_sched #(
   parameter int unsigned LEN     = 8,
   parameter int unsigned AW      = 3,
   parameter int unsigned VW      = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_rd_en,
   output logic [AW-1:0]     o_rd_addr,
   input  logic [7:0]        i_rd_data,
   output logic              o_clr,
   output logic              o_ex_valid,
   output logic [7:0]        o_ex_x,
   input  logic              i_ex_done,
   input  logic [8:0]        i_ex,
   output logic              o_var_valid,
   output logic [9:0]        o_var_x,
   input  logic              i_var_done,
   input  logic [VW-1:0]     i_var,
   output logic              o_busy,
   output logic              o_done,
   output logic [8:0]        o_mean,
   output logic [VW-1:0]     o_var,
   output logic              o_err
);

   localparam int unsigned XW  = 8;
   localparam int unsigned MW  = 9;
   localparam int unsigned DW  = 10;
   localparam int unsigned WCW = $clog2(TIMEOUT + 1);

   localparam logic [AW-1:0]  LAST_ADDR = AW'(LEN - 1);
   localparam logic [WCW-1:0] WAIT_MAX  = WCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EX_RD,
      S_EX_WAIT,
      S_VAR_RD,
      S_VAR_WAIT,
      S_DONE
   } state_t;

   state_t          state_q,     state_nxt;
   logic [AW-1:0]   addr_q,      addr_nxt;
   logic [WCW-1:0]  wcnt_q,      wcnt_nxt;
   logic            rd_en_q,     rd_en_nxt;
   logic            clr_q,       clr_nxt;
   logic            ex_valid_q,  ex_valid_nxt;
   logic            var_valid_q, var_valid_nxt;
   logic            busy_q,      busy_nxt;
   logic            done_q,      done_nxt;
   logic [MW-1:0]   mean_q,      mean_nxt;
   logic [VW-1:0]   var_q,       var_nxt;
   logic            err_q,       err_nxt;

   logic [DW-1:0]   elem_ext;
   logic [DW-1:0]   mean_ext;

   // Sequencing, wait timeout and abort handling
   always_comb begin
      state_nxt     = state_q;
      addr_nxt      = '0;
      wcnt_nxt      = '0;
      clr_nxt       = 1'b0;
      mean_nxt      = mean_q;
      var_nxt       = var_q;
      err_nxt       = err_q;
      ex_valid_nxt  = rd_en_q && (state_q == S_EX_RD);
      var_valid_nxt = rd_en_q && (state_q == S_VAR_RD);

      if ((state_q != S_IDLE) && i_abort) begin
         state_nxt     = S_IDLE;
         ex_valid_nxt  = 1'b0;
         var_valid_nxt = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start && !i_abort) begin
                  state_nxt = S_EX_RD;
                  err_nxt   = 1'b0;
                  clr_nxt   = 1'b1;
               end
            end
            S_EX_RD: begin
               if (addr_q == LAST_ADDR) begin
                  state_nxt = S_EX_WAIT;
               end else begin
                  addr_nxt = addr_q + AW'(1);
               end
            end
            S_EX_WAIT: begin
               // A done coinciding with the trailing element is premature
               if (i_ex_done && !ex_valid_q) begin
                  mean_nxt  = i_ex;
                  state_nxt = S_VAR_RD;
               end else if (wcnt_q == WAIT_MAX) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  wcnt_nxt = wcnt_q + WCW'(1);
               end
            end
            S_VAR_RD: begin
               if (addr_q == LAST_ADDR) begin
                  state_nxt = S_VAR_WAIT;
               end else begin
                  addr_nxt = addr_q + AW'(1);
               end
            end
            S_VAR_WAIT: begin
               if (i_var_done && !var_valid_q) begin
                  var_nxt   = i_var;
                  state_nxt = S_DONE;
               end else if (wcnt_q == WAIT_MAX) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  wcnt_nxt = wcnt_q + WCW'(1);
               end
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end

      rd_en_nxt = (state_nxt == S_EX_RD) || (state_nxt == S_VAR_RD);
      busy_nxt  = (state_nxt != S_IDLE);
      done_nxt  = (state_nxt == S_DONE);
   end

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wcnt_q      <= '0;
         rd_en_q     <= 1'b0;
         clr_q       <= 1'b0;
         ex_valid_q  <= 1'b0;
         var_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mean_q      <= '0;
         var_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         addr_q      <= addr_nxt;
         wcnt_q      <= wcnt_nxt;
         rd_en_q     <= rd_en_nxt;
         clr_q       <= clr_nxt;
         ex_valid_q  <= ex_valid_nxt;
         var_valid_q <= var_valid_nxt;
         busy_q      <= busy_nxt;
         done_q      <= done_nxt;
         mean_q      <= mean_nxt;
         var_q       <= var_nxt;
         err_q       <= err_nxt;
      end
   end

   // Buffer data arrives one cycle after the read, so element paths are pass-through
   assign elem_ext = {{(DW - XW){i_rd_data[XW-1]}}, i_rd_data};
   assign mean_ext = {{(DW - MW){mean_q[MW-1]}}, mean_q};

   assign o_ex_x      = ex_valid_q  ? i_rd_data             : '0;
   assign o_var_x     = var_valid_q ? (elem_ext - mean_ext) : '0;

   assign o_rd_en     = rd_en_q;
   assign o_rd_addr   = addr_q;
   assign o_clr       = clr_q;
   assign o_ex_valid  = ex_valid_q;
   assign o_var_valid = var_valid_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_mean      = mean_q;
   assign o_var       = var_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_ln_stat_sched.sv
// Bench for ln_stat_sched: buffer and Ex/Var unit stubs, queue scoreboard
// fed from a vector-level model, directed corner cases plus random vectors.
`timescale 1ns/1ps
module tb_ln_stat_sched;

   localparam int unsigned LEN     = 8;
   localparam int unsigned AW      = 3;
   localparam int unsigned VW      = 16;
   localparam int unsigned TIMEOUT = 64;

   logic                 clk   = 1'b0;
   logic                 rst   = 1'b1;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic signed [7:0]    rd_data = '0;
   logic                 clr;
   logic                 ex_valid;
   logic signed [7:0]    ex_x;
   logic                 ex_done;
   logic signed [8:0]    ex_in;
   logic                 var_valid;
   logic signed [9:0]    var_x;
   logic                 var_done;
   logic [VW-1:0]        var_in;
   logic                 busy;
   logic                 done;
   logic signed [8:0]    mean;
   logic [VW-1:0]        var_res;
   logic                 err;

   ln_stat_sched #(.LEN(LEN), .AW(AW), .VW(VW), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
      .o_clr(clr), .o_ex_valid(ex_valid), .o_ex_x(ex_x),
      .i_ex_done(ex_done), .i_ex(ex_in),
      .o_var_valid(var_valid), .o_var_x(var_x),
      .i_var_done(var_done), .i_var(var_in),
      .o_busy(busy), .o_done(done), .o_mean(mean), .o_var(var_res), .o_err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic signed [7:0] mem [LEN];
   int basic_vals [LEN] = '{-1, -2, -3, -4, -5, -6, -7, -7};

   // Stub configuration
   bit             ex_mute      = 1'b0;
   bit             ex_force     = 1'b0;
   int             ex_force_val = 0;
   int             ex_lat       = 2;
   int             var_lat      = 2;
   logic [VW-1:0]  var_ret      = '0;

   logic              spur_done = 1'b0;
   logic signed [8:0] spur_val  = '0;
   logic              stub_ex_done = 1'b0;
   logic signed [8:0] stub_ex = '0;
   logic              stub_var_done = 1'b0;
   logic [VW-1:0]     stub_var = '0;
   int ex_cnt = 0, ex_sum = 0, ex_wait = 0;
   int var_cnt_s = 0, var_wait = 0;

   assign ex_done  = stub_ex_done | spur_done;
   assign ex_in    = spur_done ? spur_val : stub_ex;
   assign var_done = stub_var_done;
   assign var_in   = stub_var;

   // Element buffer: one-cycle read latency
   always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'sd0;

   // Mean unit stub: accumulates the stream, answers floor(sum/LEN) after ex_lat cycles
   always @(posedge clk) begin
      stub_ex_done <= 1'b0;
      if (clr) begin
         ex_cnt <= 0; ex_sum <= 0; ex_wait <= 0;
      end else if (ex_valid) begin
         ex_cnt <= ex_cnt + 1;
         ex_sum <= ex_sum + int'(ex_x);
         if (ex_cnt == int'(LEN) - 1) ex_wait <= ex_lat;
      end else if (ex_wait > 0) begin
         ex_wait <= ex_wait - 1;
         if (ex_wait == 1 && !ex_mute) begin
            stub_ex_done <= 1'b1;
            stub_ex      <= ex_force ? 9'(ex_force_val) : 9'(ex_sum >>> AW);
         end
      end
   end

   // Variance unit stub: answers var_ret after var_lat cycles once LEN values arrived
   always @(posedge clk) begin
      stub_var_done <= 1'b0;
      if (clr) begin
         var_cnt_s <= 0; var_wait <= 0;
      end else if (var_valid) begin
         var_cnt_s <= var_cnt_s + 1;
         if (var_cnt_s == int'(LEN) - 1) var_wait <= var_lat;
      end else if (var_wait > 0) begin
         var_wait <= var_wait - 1;
         if (var_wait == 1) begin
            stub_var_done <= 1'b1;
            stub_var      <= var_ret;
         end
      end
   end

   int exp_addr_q[$];
   int exp_ex_q[$];
   int exp_var_q[$];
   int exp_mean_q[$];
   int exp_vres_q[$];
   int clr_cnt = 0, done_cnt = 0, var_cnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: output with no expected entry at %0t", name, $time);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an output
   always @(negedge clk) begin
      if (!rst) begin
         if (clr)       clr_cnt++;
         if (done)      done_cnt++;
         if (var_valid) var_cnt++;
         if (rd_en) begin
            if (exp_addr_q.size() == 0) unexpected("rd_addr");
            else check("rd_addr", longint'(rd_addr), exp_addr_q.pop_front());
         end
         if (ex_valid) begin
            if (exp_ex_q.size() == 0) unexpected("ex_x");
            else check("ex_x", ex_x, exp_ex_q.pop_front());
         end
         if (var_valid) begin
            if (exp_var_q.size() == 0) unexpected("var_x");
            else check("var_x", var_x, exp_var_q.pop_front());
         end
         if (done) begin
            if (exp_mean_q.size() == 0) unexpected("done");
            else begin
               check("done_mean", mean, exp_mean_q.pop_front());
               check("done_var", longint'(var_res), exp_vres_q.pop_front());
            end
         end
      end
   end

   function automatic int floor_div(input int n, input int d);
      int r;
      r = ((n % d) + d) % d;
      return (n - r) / d;
   endfunction

   // Model: mode 0 full run, 1 stops after pass 1, 2 aborted at pass-2 address k
   task automatic push_expect(input int mode, input int k);
      int sum, m;
      sum = 0;
      for (int i = 0; i < int'(LEN); i++) begin
         exp_addr_q.push_back(i);
         exp_ex_q.push_back(int'(mem[i]));
         sum += int'(mem[i]);
      end
      if (mode == 1) return;
      m = ex_force ? ex_force_val : floor_div(sum, int'(LEN));
      for (int i = 0; i < int'(LEN); i++) begin
         if (mode == 2 && i > k) break;
         exp_addr_q.push_back(i);
         if (mode != 2 || i < k) exp_var_q.push_back(int'(mem[i]) - m);
      end
      if (mode == 0) begin
         exp_mean_q.push_back(m);
         exp_vres_q.push_back(int'(var_ret));
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_vec();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy && n < 400) begin n++; tick(); end
      if (busy) begin
         checks++; errors++;
         $display("FAIL %s: still busy after %0d cycles", name, n);
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 400) begin n++; tick(); end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s: no done within %0d cycles", name, n);
      end
   endtask

   task automatic check_drained(input string name);
      check({name, "_addr_left"}, exp_addr_q.size(), 0);
      check({name, "_ex_left"},   exp_ex_q.size(),   0);
      check({name, "_var_left"},  exp_var_q.size(),  0);
      check({name, "_done_left"}, exp_mean_q.size(), 0);
   endtask

   task automatic load_basic();
      for (int i = 0; i < int'(LEN); i++) mem[i] = 8'(basic_vals[i]);
   endtask

   function automatic logic [63:0] out_bits();
      return 64'({rd_en, rd_addr, clr, ex_valid, ex_x, var_valid, var_x,
                  busy, done, mean, var_res, err});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0, d0, v0, fired;
      logic [VW-1:0] prev_var;

      load_basic();
      repeat (3) tick();
      check("reset_outputs", longint'(out_bits()), 0);
      rst = 1'b0;
      tick();

      // Basic run
      ex_force = 0; var_ret = 16'd35; ex_lat = 2; var_lat = 2;
      c0 = clr_cnt; d0 = done_cnt;
      push_expect(0, 0);
      start_vec();
      wait_idle("basic", n);
      check("basic_clr_pulses", clr_cnt - c0, 1);
      check("basic_done_pulses", done_cnt - d0, 1);
      check("basic_mean", mean, -5);
      check("basic_var", longint'(var_res), 35);
      check_drained("basic");

      // Extremes of the centred range
      for (int e = 0; e < 2; e++) begin
         for (int i = 0; i < int'(LEN); i++) mem[i] = (e == 0) ? -8'sd128 : 8'sd127;
         ex_force = 1; ex_force_val = (e == 0) ? 127 : -128;
         var_ret = 16'($urandom);
         push_expect(0, 0);
         start_vec();
         wait_idle("extreme", n);
         check("extreme_mean", mean, ex_force_val);
         check_drained("extreme");
      end
      prev_var = var_ret;

      // Abort in the 4th pass-2 read cycle
      load_basic(); ex_force = 0;
      v0 = var_cnt; d0 = done_cnt;
      push_expect(2, 3);
      start_vec();
      n = 0;
      for (int c = 0; c < 80; c++) begin
         if (rd_en) n++;
         if (rd_en && n == int'(LEN) + 4) break;
         tick();
      end
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_rd_en", rd_en, 0);
      check("abort_var_valid", var_valid, 0);
      tick(); tick();
      check("abort_var_count", var_cnt - v0, 3);
      check("abort_done_pulses", done_cnt - d0, 0);
      check("abort_mean_kept", mean, -5);
      check("abort_var_kept", longint'(var_res), longint'(prev_var));
      check_drained("abort");

      // Mean unit never answers
      ex_mute = 1; d0 = done_cnt;
      push_expect(1, 0);
      start_vec();
      wait_idle("timeout", n);
      check("timeout_busy_cycles", n, LEN + TIMEOUT);
      check("timeout_err", err, 1);
      check("timeout_done_pulses", done_cnt - d0, 0);
      check_drained("timeout");
      tick();
      check("err_held_idle", err, 1);
      ex_mute = 0; var_ret = 16'd35;
      push_expect(0, 0);
      start_vec();
      check("err_cleared_on_start", err, 0);
      wait_idle("after_timeout", n);
      check("after_timeout_err", err, 0);
      check_drained("after_timeout");

      // Spurious done during reads and on the trailing element, start while busy
      d0 = done_cnt;
      push_expect(0, 0);
      start_vec();
      n = 0; fired = 0;
      for (int c = 0; c < 40 && fired < 2; c++) begin
         spur_done = 1'b0; start = 1'b0;
         if (rd_en) n++;
         if (rd_en && n == 3) begin
            spur_done = 1'b1; spur_val = 9'sh0AA; start = 1'b1; fired++;
         end else if (!rd_en && ex_valid && n == int'(LEN) && fired == 1) begin
            spur_done = 1'b1; spur_val = 9'sh055; fired++;
         end
         tick();
      end
      spur_done = 1'b0; start = 1'b0;
      wait_idle("spurious", n);
      check("spurious_done_pulses", done_cnt - d0, 1);
      check("spurious_mean", mean, -5);
      check("spurious_var", longint'(var_res), 35);
      check_drained("spurious");

      // Reset while waiting for the mean
      ex_mute = 1;
      push_expect(1, 0);
      start_vec();
      n = 0;
      for (int c = 0; c < 20 && n < int'(LEN); c++) begin
         if (rd_en) n++;
         tick();
      end
      tick();
      rst = 1'b1; tick();
      check("midrun_reset_outputs", longint'(out_bits()), 0);
      rst = 1'b0; tick();
      check("midrun_reset_idle", busy, 0);
      ex_mute = 0;
      check_drained("midrun_reset");

      // Start together with abort in IDLE
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("start_abort_busy", busy, 0);
         check("start_abort_rd_en", rd_en, 0);
         tick();
      end

      // Random vectors, some started the cycle after done
      d0 = done_cnt;
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < int'(LEN); i++) mem[i] = 8'($urandom_range(0, 255));
         ex_force = 1'($urandom_range(0, 1));
         ex_force_val = int'($urandom_range(0, 255)) - 128;
         var_ret = 16'($urandom);
         ex_lat  = int'($urandom_range(1, 4));
         var_lat = int'($urandom_range(1, 4));
         push_expect(0, 0);
         start_vec();
         wait_done("random");
         tick();
         repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle("random_tail", n);
      check("random_done_pulses", done_cnt - d0, 16);
      check_drained("random");

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ln_stat_sched.md
Name: ln_stat_sched

Overview:
- Sequencer for the two-pass LayerNorm statistics datapath.
- On a start command it reads one LEN-element int8 vector from an external element buffer and streams it into the mean (Ex) unit.
- It latches the returned mean, then re-reads the same vector and streams mean-centred values into the variance unit.
- It reports the mean and variance with a one-cycle done pulse. It owns accumulator clearing, abort and timeout handling for both units.

Parameters:
- LEN, 8, elements per vector; power of two, ≥2.
- AW, 3, buffer address width = log2(LEN).
- VW, 16, variance result width.
- TIMEOUT, 64, max cycles spent in a wait state before error.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  begin a vector; honoured only in IDLE.
- i_abort  in  1  synchronous abort to IDLE.
- o_rd_en  out  1  buffer read strobe.
- o_rd_addr  out  AW  buffer read address.
- i_rd_data  in  8  signed element; valid exactly 1 cycle after o_rd_en.
- o_clr  out  1  one-cycle clear to the Ex and variance units.
- o_ex_valid  out  1  element valid to Ex unit.
- o_ex_x  out  8  signed element to Ex unit.
- i_ex_done  in  1  Ex unit result ready.
- i_ex  in  9  signed mean from Ex unit.
- o_var_valid  out  1  centred value valid to variance unit.
- o_var_x  out  10  signed centred value x - mean.
- i_var_done  in  1  variance unit result ready.
- i_var  in  VW  unsigned variance.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_mean  out  9  latched signed mean.
- o_var  out  VW  latched variance.
- o_err  out  1  timeout flag.

Behaviour:
- Reset: clock is i_clk; reset is synchronous and active-high, applied on i_clk. While i_rst=1 the FSM goes to IDLE, all outputs and counters are 0, and o_mean, o_var and o_err are cleared. Reset mid-operation discards the vector. No o_done is produced.
- States are IDLE, EX_RD, EX_WAIT, VAR_RD, VAR_WAIT, DONE.
- IDLE: on i_start=1 and i_abort=0, clear o_err, go to EX_RD. Abort wins over a simultaneous start.
- EX_RD (LEN cycles):
  - o_rd_en=1, o_rd_addr = 0..LEN-1, one address per cycle.
  - o_clr=1 in the first EX_RD cycle only.
  - After address LEN-1, go to EX_WAIT.
- Data pipeline (both passes): a registered copy of o_rd_en drives the valid. o_ex_valid (pass 1) or o_var_valid (pass 2) is high for exactly LEN consecutive cycles, starting 1 cycle after the first o_rd_en. The last valid lands in the first wait-state cycle.
- Pass 1 data: o_ex_x = i_rd_data.
- EX_WAIT:
  - i_ex_done is honoured only in cycles where o_ex_valid=0.
  - On done: o_mean <= i_ex, then go to VAR_RD.
  - An early or spurious i_ex_done is ignored.
- VAR_RD: same as EX_RD, but with no o_clr.
- Pass 2 data: o_var_x = sext10(i_rd_data) - sext10(o_mean). Range is -256..+255, so there is no overflow.
- VAR_WAIT: i_var_done is honoured when o_var_valid=0. On done: o_var <= i_var, then go to DONE.
- DONE (1 cycle): o_done=1, then IDLE. o_mean and o_var hold until the next accepted start (o_mean is overwritten in EX_WAIT).
- Timeout:
  - A wait counter resets on entry to EX_WAIT or VAR_WAIT.
  - If the wait reaches TIMEOUT cycles without done: o_err=1, go to IDLE, no o_done.
  - o_err stays set until reset or the next accepted start.
- Abort: i_abort=1 in any non-IDLE state forces IDLE next cycle. o_rd_en and the valids drop next cycle, the in-flight delayed valid is squashed, and no o_done is produced. o_mean and o_var keep their prior values.
- i_start outside IDLE is ignored.
- Back-to-back: a start in the cycle after DONE is accepted normally.

Test Plan:
- Basic run, with the buffer holding [-1,-2,-3,-4,-5,-6,-7,-7]:
  - Start: 8 reads on addresses 0..7 and one o_clr pulse.
  - o_ex_x stream is -1..-7,-7.
  - Ex stub returns -5 (floor(-35/8)) two cycles later. o_var_x stream is 4,3,2,1,0,-1,-2,-2.
  - Var stub returns 35 (0x0023). o_done pulses once with o_mean=-5, o_var=35.
- Extremes, with the buffer all -128 and the stub mean 127: every o_var_x = -255. With buffer +127 and mean -128: every o_var_x = 255.
- Abort in the 4th VAR_RD cycle: IDLE next cycle, no o_done, o_var_valid count is at most 4, o_mean keeps -5, o_busy=0.
- Ex stub never raises done: after TIMEOUT=64 EX_WAIT cycles, o_err=1, IDLE, no o_done. The next start clears o_err.
- Spurious i_ex_done during EX_RD, plus i_start asserted while busy: both are ignored, and the sequence completes with the same results as the basic run.
- Reset asserted in EX_WAIT: next cycle all outputs are 0 and the state is IDLE. Start plus abort together in IDLE: stays IDLE, no reads.
